bp_cce_lce_cmd_tx_buffer: RTL and testbench
===========================================

Name: bp_cce_lce_cmd_tx_buffer

Overview:
Outbound LCE command buffer at the transmit end of the CCE's lce_cmd valid/ready interface. It accepts commands from the CCE message unit or microcode datapath and holds them in a small circular FIFO. It drains them to the coherence network with a valid/ready handshake. It produces the lce_cmd_ready signal consumed by CCE stall detection, plus occupancy and sent-command counters for the perf monitor.

Parameters:
- width_p, 128, bit width of one LCE command message
- els_p, 2, FIFO depth in entries; any value ≥2, not required to be a power of two
- cnt_width_p, 16, width of the saturating sent-command counter

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- lce_cmd_i  in  width_p  command from CCE
- lce_cmd_v_i  in  1  CCE offers command
- lce_cmd_ready_o  out  1  buffer can accept a command this cycle
- lce_cmd_o  out  width_p  command to network, head of FIFO
- lce_cmd_v_o  out  1  head entry valid
- lce_cmd_ready_i  in  1  network accepts head
- empty_o  out  1  no entries held
- occupancy_o  out  clog2(els_p+1)  entries held
- clr_cnt_i  in  1  synchronous clear of the sent counter
- sent_count_o  out  cnt_width_p  commands delivered to network

Behaviour:
- Reset (reset_n_i low, asynchronous): rd/wr pointers=0, occupancy=0, sent count=0, lce_cmd_v_o=0, empty_o=1, lce_cmd_ready_o=1. Storage contents are don't-care. No enqueue or dequeue takes effect while reset is asserted. Deassertion is synchronous to clk_i externally.
- Enqueue: enq = lce_cmd_v_i & lce_cmd_ready_o. It writes lce_cmd_i at wr_ptr on the clock edge. lce_cmd_v_i while ready is low is ignored; the stall unit guarantees replay.
- lce_cmd_ready_o = (occupancy < els_p). It is a function of registered state only, with no combinational path from lce_cmd_ready_i.
- Dequeue: deq = lce_cmd_v_o & lce_cmd_ready_i, where lce_cmd_v_o = (occupancy != 0). lce_cmd_o = mem[rd_ptr], driven combinationally from storage.
- Latency: no bypass. A command enqueued in cycle N is first visible on lce_cmd_o/lce_cmd_v_o in cycle N+1. Minimum latency is 1 cycle; throughput is 1 per cycle when els_p≥2.
- Pointers wrap from els_p-1 to 0. For non-power-of-two depth this uses an explicit compare, not bit truncation.
- Occupancy updates:
  - enq only: +1
  - deq only: -1
  - enq and deq together: unchanged, both pointers advance
- Full with deq in the same cycle: enq is not accepted (ready low that cycle); occupancy goes to els_p-1.
- Empty: deq is impossible; lce_cmd_ready_i is ignored.
- lce_cmd_o holds its value while lce_cmd_v_o & ~lce_cmd_ready_i. The head is stable until accepted, which is the network valid/ready contract.
- Sent counter:
  - increments on deq
  - saturates at 2^cnt_width_p-1
  - clr_cnt_i has priority: clear together with deq gives 0 next cycle
- Assertions (sim only): occupancy ≤ els_p; never enq when full.

Decomposition:
- bp_cce_pkg: add a bp_cce_lce_cmd_s packed typedef if not already present. width_p defaults to its width at integration.
- One sub-module, bp_cce_circ_ptr (parameters els_p; inputs clk_i, reset_n_i, incr_i; output ptr_o). It is instantiated twice, for the read and write pointers.
- Occupancy and sent counters stay inline.

Test Plan:
- Reset then idle: after reset_n_i release, expect ready_o=1, v_o=0, empty_o=1, occupancy 0, sent 0. Assert reset_n_i low mid-burst with 2 entries held → all outputs return to reset values asynchronously, before the next clock edge.
- Fill/full (els_p=2, ready_i=0): enqueue 0xA1 and 0xA2 on consecutive cycles → occupancy 2, ready_o=0. A third v_i with 0xA3 is ignored. Then ready_i=1 → network sees 0xA1 then 0xA2; 0xA3 is never seen.
- Streaming: v_i=1 and ready_i=1 for 10 cycles with data 0..9 → output 0..9 in order, each one cycle after enqueue. Occupancy stays ≤1, sent_count=10.
- Backpressure stability: head 0x55 with ready_i=0 for 5 cycles → lce_cmd_o=0x55 and v_o=1 each cycle. On release, 0x55 is delivered once.
- Wrap with els_p=3: push/pop 7 commands in mixed patterns → ordering is preserved across pointer wraps, and occupancy returns to 0.
- Counter (cnt_width_p=2): 5 dequeues → sent_count saturates at 3. clr_cnt_i together with a dequeue → 0; the next dequeue → 1.

Source files
------------

// File: rtl/bp_cce_pkg.sv
// bp_cce_pkg: shared CCE types; the LCE command message layout sets the default buffer width.
`default_nettype none

package bp_cce_pkg;

  localparam int lce_cmd_addr_width_gp = 40;
  localparam int lce_cmd_data_width_gp = 76;

  typedef enum logic [3:0] {
    e_lce_cmd_sync       = 4'h0,
    e_lce_cmd_set_clear  = 4'h1,
    e_lce_cmd_transfer   = 4'h2,
    e_lce_cmd_writeback  = 4'h3,
    e_lce_cmd_set_tag    = 4'h4,
    e_lce_cmd_invalidate = 4'h5,
    e_lce_cmd_data       = 4'h6
  } bp_cce_lce_cmd_type_e;

  typedef struct packed {
    bp_cce_lce_cmd_type_e              msg_type;
    logic [3:0]                        dst_id;
    logic [3:0]                        way_id;
    logic [lce_cmd_addr_width_gp-1:0]  addr;
    logic [lce_cmd_data_width_gp-1:0]  data;
  } bp_cce_lce_cmd_s;

endpackage

`default_nettype wire

// File: rtl/bp_cce_circ_ptr.sv
// bp_cce_circ_ptr: modulo-els_p pointer; wraps by explicit compare so any depth >= 2 works.
`default_nettype none

module bp_cce_circ_ptr #(
  parameter  int els_p        = 2,
  localparam int ptr_width_lp = $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    incr_i,
  output logic [ptr_width_lp-1:0] ptr_o
);

  localparam logic [ptr_width_lp-1:0] last_lp = ptr_width_lp'(els_p - 1);

  logic [ptr_width_lp-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (incr_i) begin
      ptr_d = (ptr_q == last_lp) ? '0 : ptr_q + ptr_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/bp_cce_lce_cmd_tx_buffer.sv
// bp_cce_lce_cmd_tx_buffer: circular FIFO between the CCE and the LCE command network (rev 1.0).
`default_nettype none

module bp_cce_lce_cmd_tx_buffer
  import bp_cce_pkg::*;
#(
  parameter  int width_p      = $bits(bp_cce_lce_cmd_s),
  parameter  int els_p        = 2,
  parameter  int cnt_width_p  = 16,
  localparam int occ_width_lp = $clog2(els_p + 1),
  localparam int ptr_width_lp = $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [width_p-1:0]      lce_cmd_i,
  input  logic                    lce_cmd_v_i,
  output logic                    lce_cmd_ready_o,
  output logic [width_p-1:0]      lce_cmd_o,
  output logic                    lce_cmd_v_o,
  input  logic                    lce_cmd_ready_i,
  output logic                    empty_o,
  output logic [occ_width_lp-1:0] occupancy_o,
  input  logic                    clr_cnt_i,
  output logic [cnt_width_p-1:0]  sent_count_o
);

  localparam logic [occ_width_lp-1:0] els_lp      = occ_width_lp'(els_p);
  localparam logic [cnt_width_p-1:0]  sent_max_lp = '1;

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] rd_ptr, wr_ptr;
  logic [occ_width_lp-1:0] occ_d, occ_q;
  logic [cnt_width_p-1:0]  sent_d, sent_q;
  logic                    enq, deq;

  // Handshake qualifiers depend only on registered occupancy, never on lce_cmd_ready_i.
  assign lce_cmd_ready_o = (occ_q < els_lp);
  assign lce_cmd_v_o     = (occ_q != '0);
  assign empty_o         = ~lce_cmd_v_o;
  assign enq             = lce_cmd_v_i & lce_cmd_ready_o;
  assign deq             = lce_cmd_v_o & lce_cmd_ready_i;
  assign lce_cmd_o       = mem_q[rd_ptr];
  assign occupancy_o     = occ_q;
  assign sent_count_o    = sent_q;

  bp_cce_circ_ptr #(.els_p(els_p)) u_rd_ptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .incr_i    (deq),
    .ptr_o     (rd_ptr)
  );

  bp_cce_circ_ptr #(.els_p(els_p)) u_wr_ptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .incr_i    (enq),
    .ptr_o     (wr_ptr)
  );

  always_comb begin
    occ_d = occ_q;
    case ({enq, deq})
      2'b10:   occ_d = occ_q + occ_width_lp'(1);
      2'b01:   occ_d = occ_q - occ_width_lp'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    sent_d = sent_q;
    if (clr_cnt_i) begin
      sent_d = '0;
    end else if (deq && (sent_q != sent_max_lp)) begin
      sent_d = sent_q + cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      occ_q  <= '0;
      sent_q <= '0;
    end else begin
      occ_q  <= occ_d;
      sent_q <= sent_d;
    end
  end

  // Storage is not reset; only entries behind a valid occupancy are ever observed.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr] <= lce_cmd_i;
  end

  a_occ_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i) occ_q <= els_lp);
  a_no_enq_full: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(enq && (occ_q == els_lp)));

endmodule

`default_nettype wire

// File: tb/tb_bp_cce_lce_cmd_tx_buffer.sv
// tb_bp_cce_lce_cmd_tx_buffer: directed checks on a depth-2 and a depth-3/2-bit-counter instance.
`default_nettype none

module tb_bp_cce_lce_cmd_tx_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: els_p=2, 16-bit counter
  logic [7:0]  a_cmd_i, a_cmd_o;
  logic        a_v_i, a_rdy_o, a_v_o, a_rdy_i, a_empty, a_clr;
  logic [1:0]  a_occ;
  logic [15:0] a_sent;

  // Instance B: els_p=3, 2-bit counter
  logic [7:0]  b_cmd_i, b_cmd_o;
  logic        b_v_i, b_rdy_o, b_v_o, b_rdy_i, b_empty, b_clr;
  logic [1:0]  b_occ;
  logic [1:0]  b_sent;

  int checks = 0;
  int errors = 0;

  bp_cce_lce_cmd_tx_buffer #(.width_p(8), .els_p(2), .cnt_width_p(16)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n),
    .lce_cmd_i(a_cmd_i), .lce_cmd_v_i(a_v_i), .lce_cmd_ready_o(a_rdy_o),
    .lce_cmd_o(a_cmd_o), .lce_cmd_v_o(a_v_o), .lce_cmd_ready_i(a_rdy_i),
    .empty_o(a_empty), .occupancy_o(a_occ), .clr_cnt_i(a_clr), .sent_count_o(a_sent)
  );

  bp_cce_lce_cmd_tx_buffer #(.width_p(8), .els_p(3), .cnt_width_p(2)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n),
    .lce_cmd_i(b_cmd_i), .lce_cmd_v_i(b_v_i), .lce_cmd_ready_o(b_rdy_o),
    .lce_cmd_o(b_cmd_o), .lce_cmd_v_o(b_v_o), .lce_cmd_ready_i(b_rdy_i),
    .empty_o(b_empty), .occupancy_o(b_occ), .clr_cnt_i(b_clr), .sent_count_o(b_sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_cmd_i = '0; a_v_i = 0; a_rdy_i = 0; a_clr = 0;
    b_cmd_i = '0; b_v_i = 0; b_rdy_i = 0; b_clr = 0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Idle after reset
    chk("a_rst_ready", {31'd0, a_rdy_o}, 32'd1);
    chk("a_rst_v",     {31'd0, a_v_o},   32'd0);
    chk("a_rst_empty", {31'd0, a_empty}, 32'd1);
    chk("a_rst_occ",   {30'd0, a_occ},   32'd0);
    chk("a_rst_sent",  {16'd0, a_sent},  32'd0);
    chk("b_rst_ready", {31'd0, b_rdy_o}, 32'd1);

    // Fill to full with network stalled; third offer is dropped
    a_cmd_i = 8'hA1; a_v_i = 1; cyc();
    a_cmd_i = 8'hA2; cyc();
    chk("fill_occ2",   {30'd0, a_occ},   32'd2);
    chk("fill_ready0", {31'd0, a_rdy_o}, 32'd0);
    chk("fill_v",      {31'd0, a_v_o},   32'd1);
    chk("fill_head",   {24'd0, a_cmd_o}, 32'hA1);
    a_cmd_i = 8'hA3; cyc();
    chk("fill_ign_occ",  {30'd0, a_occ},   32'd2);
    chk("fill_ign_head", {24'd0, a_cmd_o}, 32'hA1);
    a_v_i = 0; a_rdy_i = 1; cyc();
    chk("drain_head2", {24'd0, a_cmd_o}, 32'hA2);
    chk("drain_occ1",  {30'd0, a_occ},   32'd1);
    cyc();
    chk("drain_empty", {31'd0, a_empty}, 32'd1);
    chk("drain_v0",    {31'd0, a_v_o},   32'd0);
    chk("drain_sent",  {16'd0, a_sent},  32'd2);
    a_rdy_i = 0; a_clr = 1; cyc();
    a_clr = 0;
    chk("clr_sent", {16'd0, a_sent}, 32'd0);

    // Streaming: each command visible the cycle after enqueue
    a_rdy_i = 1; a_v_i = 1;
    for (int i = 0; i < 10; i++) begin
      a_cmd_i = 8'(i);
      cyc();
      chk("stream_data", {24'd0, a_cmd_o}, 32'(i));
      chk("stream_occ",  {30'd0, a_occ},   32'd1);
    end
    a_v_i = 0; cyc();
    chk("stream_sent", {16'd0, a_sent}, 32'd10);
    chk("stream_occ0", {30'd0, a_occ},  32'd0);

    // Backpressure: head held stable
    a_rdy_i = 0; a_v_i = 1; a_cmd_i = 8'h55; cyc();
    a_v_i = 0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_head", {24'd0, a_cmd_o}, 32'h55);
      chk("bp_v",    {31'd0, a_v_o},   32'd1);
      cyc();
    end
    a_rdy_i = 1; cyc();
    chk("bp_occ0",  {30'd0, a_occ},  32'd0);
    chk("bp_sent",  {16'd0, a_sent}, 32'd11);
    cyc();
    chk("bp_once",  {16'd0, a_sent}, 32'd11);

    // Asynchronous reset with two entries held
    a_rdy_i = 0; a_v_i = 1; a_cmd_i = 8'hB1; cyc();
    a_cmd_i = 8'hB2; cyc();
    a_v_i = 0;
    chk("ar_pre_occ", {30'd0, a_occ}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ready", {31'd0, a_rdy_o}, 32'd1);
    chk("ar_v",     {31'd0, a_v_o},   32'd0);
    chk("ar_empty", {31'd0, a_empty}, 32'd1);
    chk("ar_occ",   {30'd0, a_occ},   32'd0);
    chk("ar_sent",  {16'd0, a_sent},  32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Wrap on depth 3
    b_rdy_i = 0; b_v_i = 1;
    b_cmd_i = 8'd1; cyc();
    b_cmd_i = 8'd2; cyc();
    b_cmd_i = 8'd3; cyc();
    chk("w_occ3",  {30'd0, b_occ},   32'd3);
    chk("w_rdy0",  {31'd0, b_rdy_o}, 32'd0);
    chk("w_head1", {24'd0, b_cmd_o}, 32'd1);
    b_v_i = 0; b_rdy_i = 1; cyc();
    chk("w_head2", {24'd0, b_cmd_o}, 32'd2);
    cyc();
    chk("w_head3", {24'd0, b_cmd_o}, 32'd3);
    chk("w_occ1",  {30'd0, b_occ},   32'd1);
    b_v_i = 1; b_cmd_i = 8'd4; cyc();
    chk("w_head4", {24'd0, b_cmd_o}, 32'd4);
    b_cmd_i = 8'd5; cyc();
    chk("w_head5", {24'd0, b_cmd_o}, 32'd5);
    chk("w_occ1b", {30'd0, b_occ},   32'd1);
    b_rdy_i = 0; b_cmd_i = 8'd6; cyc();
    b_cmd_i = 8'd7; cyc();
    chk("w_occ3b",  {30'd0, b_occ},   32'd3);
    chk("w_head5b", {24'd0, b_cmd_o}, 32'd5);
    // Full with dequeue: the offered 0x99 is refused
    b_cmd_i = 8'h99; b_rdy_i = 1; cyc();
    b_v_i = 0;
    chk("w_fulldeq_occ", {30'd0, b_occ},   32'd2);
    chk("w_head6",       {24'd0, b_cmd_o}, 32'd6);
    cyc();
    chk("w_head7", {24'd0, b_cmd_o}, 32'd7);
    cyc();
    chk("w_occ0",  {30'd0, b_occ},   32'd0);
    chk("w_empty", {31'd0, b_empty}, 32'd1);
    chk("w_sent_sat", {30'd0, b_sent}, 32'd3);

    // Saturating 2-bit counter
    b_clr = 1; cyc();
    b_clr = 0;
    chk("c_clr", {30'd0, b_sent}, 32'd0);
    b_v_i = 1;
    for (int k = 0; k < 5; k++) begin
      b_cmd_i = 8'(8'h10 + k);
      cyc();
    end
    b_v_i = 0; cyc();
    chk("c_sat",  {30'd0, b_sent}, 32'd3);
    chk("c_occ0", {30'd0, b_occ},  32'd0);
    b_v_i = 1; b_cmd_i = 8'h20; cyc();
    b_v_i = 0; b_clr = 1; cyc();
    b_clr = 0;
    chk("c_clr_deq", {30'd0, b_sent}, 32'd0);
    chk("c_occ0b",   {30'd0, b_occ},  32'd0);
    b_v_i = 1; b_cmd_i = 8'h21; cyc();
    b_v_i = 0; cyc();
    chk("c_after_clr", {30'd0, b_sent}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
